// File: rtl/hilo_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_unit
// Description : Multi-cycle integer multiply/divide engine owning the
//               architectural HI/LO registers. Executes MULT/MULTU/DIV/DIVU
//               and MTHI/MTLO, and requests a pipeline stall while a
//               multiply or divide is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw rs operand
  logic [WIDTH-1:0]   b_q, b_d;          // raw rt operand
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic [2*WIDTH-1:0] work_q, work_d;    // product, or {remainder, dividend/quotient}
  logic               sgn_q, sgn_d;
  logic               is_div_q, is_div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  // An MTHI/MTLO accepted in DONE is written one edge after the commit so
  // that it lands after the older multiply/divide result.
  logic               pend_hi_q, pend_hi_d;
  logic               pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0]   pend_val_q, pend_val_d;

  // Datapath helpers: operand magnitudes, product, divide step, sign fixup.
  logic               in_signed;
  logic [WIDTH-1:0]   in0_mag, in1_mag;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept_slot;

  assign in_signed = ~op[0];
  assign in0_mag   = (in_signed && in0[WIDTH-1]) ? -in0 : in0;
  assign in1_mag   = (in_signed && in1[WIDTH-1]) ? -in1 : in1;

  assign mul_a   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mul_b   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product = mul_a * mul_b;

  assign div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};

  assign quo_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -work_q[WIDTH-1:0]
                                                             : work_q[WIDTH-1:0];
  assign rem_fix = (sgn_q && a_q[WIDTH-1]) ? -work_q[2*WIDTH-1:WIDTH]
                                           : work_q[2*WIDTH-1:WIDTH];

  assign accept_slot = (state_q == S_IDLE) || (state_q == S_DONE);

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    dvs_d      = dvs_q;
    work_d     = work_q;
    sgn_d      = sgn_q;
    is_div_d   = is_div_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = 1'b0;
    pend_lo_d  = 1'b0;
    pend_val_d = pend_val_q;

    // A deferred move belongs to an already-accepted instruction, so it is
    // applied even when this cycle is flushed.
    if (pend_hi_q) hi_d = pend_val_q;
    if (pend_lo_q) lo_d = pend_val_q;

    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (state_q == S_DONE) begin
            if (!is_div_q) begin
              hi_d = work_q[2*WIDTH-1:WIDTH];
              lo_d = work_q[WIDTH-1:0];
            end else if (b_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
          state_d = S_IDLE;
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_d      = in0;
                b_d      = in1;
                sgn_d    = in_signed;
                is_div_d = 1'b0;
                state_d  = S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                a_d      = in0;
                b_d      = in1;
                sgn_d    = in_signed;
                is_div_d = 1'b1;
                dvs_d    = in1_mag;
                work_d   = {{WIDTH{1'b0}}, in0_mag};
                cnt_d    = '0;
                state_d  = S_DIV;
              end
              OP_MTHI: begin
                if (state_q == S_DONE) begin
                  pend_hi_d  = 1'b1;
                  pend_val_d = in0;
                end else begin
                  hi_d = in0;
                end
              end
              OP_MTLO: begin
                if (state_q == S_DONE) begin
                  pend_lo_d  = 1'b1;
                  pend_val_d = in0;
                end else begin
                  lo_d = in0;
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          work_d  = product;
          state_d = S_DONE;
        end
        S_DIV: begin
          work_d = div_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      dvs_q      <= '0;
      work_q     <= '0;
      sgn_q      <= 1'b0;
      is_div_q   <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_hi_q  <= 1'b0;
      pend_lo_q  <= 1'b0;
      pend_val_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      dvs_q      <= dvs_d;
      work_q     <= work_d;
      sgn_q      <= sgn_d;
      is_div_q   <= is_div_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign stall = busy_q | (start & ~cancel & accept_slot & ~op[2]);
  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv_unit
// Description : Scoreboard bench for hilo_muldiv_unit at WIDTH=32 and WIDTH=8.
//               Expected HI/LO values come from a plain-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn, start, cancel;
  logic [2:0]  op;
  logic [31:0] in0, in1;

  logic        stall32, busy32, done32;
  logic [31:0] hi32, lo32;
  logic        stall8, busy8, done8;
  logic [7:0]  hi8, lo8;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .in0(in0), .in1(in1),
    .cancel(cancel), .stall(stall32), .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32)
  );

  hilo_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .in0(in0[7:0]), .in1(in1[7:0]),
    .cancel(cancel), .stall(stall8), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8)
  );

  // sel chooses which instance is under check; w is its width.
  int          sel = 0;
  int          w   = 32;
  logic        s_stall, s_busy, s_done;
  logic [31:0] s_hi, s_lo;

  always_comb begin
    s_stall = sel ? stall8 : stall32;
    s_busy  = sel ? busy8  : busy32;
    s_done  = sel ? done8  : done32;
    s_hi    = sel ? {24'd0, hi8} : hi32;
    s_lo    = sel ? {24'd0, lo8} : lo32;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi, m_lo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, width %0d)", nm, act, exp, cyc, w);
    end
  endtask

  // Reference model: HI/LO after one multiply/divide, from plain integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int wd, output logic [31:0] h, output logic [31:0] l);
    longint unsigned mask, ua, ub, p;
    longint          sa, sb, q, r;
    mask = (64'd1 << wd) - 64'd1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = a[wd-1] ? longint'(ua) - (longint'(1) << wd) : longint'(ua);
    sb   = b[wd-1] ? longint'(ub) - (longint'(1) << wd) : longint'(ub);
    h = 32'd0;
    l = 32'd0;
    case (o)
      3'd0: begin p = 64'(sa * sb); h = 32'((p >> wd) & mask); l = 32'(p & mask); end
      3'd1: begin p = ua * ub;      h = 32'((p >> wd) & mask); l = 32'(p & mask); end
      3'd2: begin
        if (ub == 0) begin h = 32'(ua); l = 32'(mask); end
        else begin q = sa / sb; r = sa % sb; h = 32'(r & longint'(mask)); l = 32'(q & longint'(mask)); end
      end
      3'd3: begin
        if (ub == 0) begin h = 32'(ua); l = 32'(mask); end
        else begin h = 32'((ua % ub) & mask); l = 32'((ua / ub) & mask); end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rval(input int wd);
    logic [31:0] one;
    one = 32'd1;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return one << (wd - 1);
      3:       return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse pops one expectation, checks its timing, then
  // checks the HI/LO values visible on the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_done === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: done=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", longint'(cyc), longint'(e.cyc));
          @(negedge clk);
          chk("result_hi", s_hi, e.hi);
          chk("result_lo", s_lo, e.lo);
        end
      end
    end
  end

  task automatic wait_idle(output int nst);
    nst = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_stall) nst++;
      if (!s_busy && !s_done) return;
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: busy=%0b done=%0b required 0 within 200 cycles", s_busy, s_done);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] mask, a, b, eh, el;
    exp_t        e;
    int          nst;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    a = a_in & mask;
    b = b_in & mask;
    @(negedge clk);
    start = 1'b1; op = o; in0 = a; in1 = b; cancel = 1'b0;
    #1 chk("stall_on_issue", s_stall, (o < 3'd4) ? 1 : 0);
    if (o < 3'd4) begin
      model(o, a, b, w, eh, el);
      e.hi  = eh;
      e.lo  = el;
      e.cyc = cyc + 1 + ((o < 3'd2) ? 1 : w);
      sbq.push_back(e);
      m_hi = eh;
      m_lo = el;
    end
    @(posedge clk);
    #1 start = 1'b0;
    if (o < 3'd4) begin
      wait_idle(nst);
      chk("stall_cycles", longint'(nst + 1), longint'(1 + ((o < 3'd2) ? 1 : w)));
    end else begin
      if (o == 3'd4) m_hi = a;
      if (o == 3'd5) m_lo = a;
      @(negedge clk);
      chk("hi_after_op", s_hi, m_hi);
      chk("lo_after_op", s_lo, m_lo);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   nst;
    logic seen;

    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; in0 = '0; in1 = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_hi", s_hi, 0);
    chk("reset_lo", s_lo, 0);
    chk("reset_busy", s_busy, 0);
    chk("reset_done", s_done, 0);
    chk("reset_stall", s_stall, 0);

    // ---------------- WIDTH = 32 ----------------
    do_op(3'd0, 32'hFFFF_FFFE, 32'h3);
    do_op(3'd1, 32'hFFFF_FFFE, 32'h3);
    do_op(3'd2, 32'hFFFF_FFF9, 32'h2);
    do_op(3'd3, 32'd100, 32'd7);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd3, 32'h1234, 32'h0);
    do_op(3'd2, 32'hFFFF_FFFB, 32'h0);

    // Cancel in the middle of a divide.
    do_op(3'd4, 32'h55, 32'h0);
    do_op(3'd5, 32'h55, 32'h0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; in0 = 32'hFFFF_FF9C; in1 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", s_busy, 0);
    chk("cancel_stall", s_stall, 0);
    chk("cancel_done", s_done, 0);
    chk("cancel_hi", s_hi, 32'h55);
    chk("cancel_lo", s_lo, 32'h55);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (s_done) seen = 1'b1;
    end
    chk("cancel_no_done", seen, 0);

    // Cancel wins over MTHI.
    @(negedge clk);
    start = 1'b1; op = 3'd4; in0 = 32'hAA; cancel = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; cancel = 1'b0; end
    @(negedge clk);
    chk("cancel_mthi_hi", s_hi, 32'h55);

    // Back-to-back: MTLO accepted in the DONE cycle of MULT 3x4.
    @(negedge clk);
    start = 1'b1; op = 3'd0; in0 = 32'd3; in1 = 32'd4;
    e.hi = 32'd0; e.lo = 32'd12; e.cyc = cyc + 2;
    sbq.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done", s_done, 1);
    start = 1'b1; op = 3'd5; in0 = 32'd9;
    #1 chk("b2b_mt_stall", s_stall, 0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_hi", s_hi, 32'd0);
    chk("b2b_lo", s_lo, 32'd9);
    m_hi = 32'd0;
    m_lo = 32'd9;

    // Start held through a divide: only the first operation executes.
    @(negedge clk);
    start = 1'b1; op = 3'd3; in0 = 32'd1000; in1 = 32'd7;
    e.hi = 32'd6; e.lo = 32'd142; e.cyc = cyc + 1 + w;
    sbq.push_back(e);
    @(posedge clk);
    #1 begin op = 3'd0; in0 = 32'd5; in1 = 32'd5; end
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_idle(nst);
    repeat (4) @(negedge clk);
    m_hi = 32'd6;
    m_lo = 32'd142;

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 3'd2; in0 = 32'd12345; in1 = 32'hFFFF_FFF9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("midreset_hi", s_hi, 0);
    chk("midreset_lo", s_lo, 0);
    chk("midreset_busy", s_busy, 0);
    chk("midreset_done", s_done, 0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int i = 0; i < 40; i++) do_op(3'($urandom_range(0, 7)), rval(w), rval(w));
    repeat (3) @(negedge clk);
    chk("scoreboard_empty_w32", longint'(sbq.size()), 0);

    // ---------------- WIDTH = 8 ----------------
    @(negedge clk);
    resetn = 1'b0;
    sel = 1;
    w = 8;
    @(posedge clk);
    #1 resetn = 1'b1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    chk("w8_reset_hi", s_hi, 0);
    chk("w8_reset_lo", s_lo, 0);

    do_op(3'd3, 32'd200, 32'd3);
    do_op(3'd0, 32'hFE, 32'h3);
    do_op(3'd1, 32'hFE, 32'h3);
    do_op(3'd2, 32'h80, 32'hFF);
    do_op(3'd2, 32'hFB, 32'h0);
    do_op(3'd2, 32'hF9, 32'h2);
    for (int i = 0; i < 40; i++) do_op(3'($urandom_range(0, 7)), rval(w), rval(w));
    pulse_reset();
    @(negedge clk);
    chk("w8_final_reset_lo", s_lo, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty_w8", longint'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
